// File: rtl/conv2d_result_writer_pkg.sv
// Shared definitions for the conv2d result writer: frame FSM encodings and default widths.
// Also reused by the compute block's controller, so keep the encodings stable.
package conv2d_result_writer_pkg;

    localparam int DWIDTH_DEF    = 32;
    localparam int AWIDTH_DEF    = 32;
    localparam int FIFO_LOGD_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wr_state_t;

    // Pixel count of a square feature map; only the low 32 bits are kept.
    function automatic logic [31:0] frame_pixels(input logic [31:0] dim);
        return dim * dim;
    endfunction

endpackage

// File: rtl/conv2d_result_writer_if.sv
// Result input strobe plus memory write-request channel of the conv2d result writer.
interface conv2d_result_writer_if
    import conv2d_result_writer_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
);
    logic [DWIDTH-1:0] wdata;
    logic              wdata_valid;
    logic              mem_wreq_valid;
    logic              mem_wreq_ready;
    logic [AWIDTH-1:0] mem_wreq_addr;
    logic [DWIDTH-1:0] mem_wreq_data;

    modport master (
        input  wdata, wdata_valid, mem_wreq_ready,
        output mem_wreq_valid, mem_wreq_addr, mem_wreq_data
    );

    modport slave (
        output wdata, wdata_valid, mem_wreq_ready,
        input  mem_wreq_valid, mem_wreq_addr, mem_wreq_data
    );
endinterface

// File: rtl/conv2d_result_fifo.sv
// Small synchronous FIFO with full/empty flags, async active-low reset and synchronous flush.
module conv2d_result_fifo
    import conv2d_result_writer_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int LOGD   = FIFO_LOGD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic [DWIDTH-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty
);
    localparam int DEPTH = 1 << LOGD;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [LOGD:0]     r_wr_ptr;
    logic [LOGD:0]     r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[LOGD] != r_rd_ptr[LOGD]) &&
                       (r_wr_ptr[LOGD-1:0] == r_rd_ptr[LOGD-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[LOGD-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[LOGD-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/conv2d_result_writer.sv
// Buffers conv2d output pixels and writes them to the output feature map in raster order.
// Optional CONV2D_WR_PERF_EN adds o_stall_cycles (RUN cycles with a request stalled by memory).
module conv2d_result_writer
    import conv2d_result_writer_pkg::*;
#(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int AWIDTH    = AWIDTH_DEF,
    parameter int FIFO_LOGD = FIFO_LOGD_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    output logic                    o_idle,
    output logic                    o_done,
    input  logic [AWIDTH-1:0]       i_ofm_base,
    input  logic [31:0]             i_fm_dim,
    output logic                    o_overflow,
    conv2d_result_writer_if.master  bus
`ifdef CONV2D_WR_PERF_EN
    ,
    output logic [31:0]             o_stall_cycles
`endif
);
    wr_state_t         r_state;
    wr_state_t         w_state_next;
    logic [31:0]       r_wr_cnt;
    logic [31:0]       r_total;
    logic [AWIDTH-1:0] r_base;
    logic              r_overflow;

    logic              w_start_frame;
    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf_set;

    assign w_valid   = (r_state == ST_RUN) & ~w_empty;
    assign w_pop     = w_valid & bus.mem_wreq_ready;
    assign w_push    = (r_state == ST_RUN) & bus.wdata_valid;
    assign w_ovf_set = w_push & w_full & ~w_pop;

    assign bus.mem_wreq_valid = w_valid;
    assign bus.mem_wreq_addr  = r_base + AWIDTH'(r_wr_cnt);
    assign o_overflow         = r_overflow;

    conv2d_result_fifo #(
        .DWIDTH (DWIDTH),
        .LOGD   (FIFO_LOGD)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_start_frame),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (bus.wdata),
        .o_rdata (bus.mem_wreq_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        o_idle        = 1'b0;
        o_done        = 1'b0;
        w_start_frame = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_idle = 1'b1;
                if (i_start) begin
                    w_start_frame = 1'b1;
                    w_state_next  = (i_fm_dim == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_pop && (r_wr_cnt == r_total - 32'd1)) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_total    <= '0;
            r_wr_cnt   <= '0;
            r_overflow <= 1'b0;
        end else if (w_start_frame) begin
            r_base     <= i_ofm_base;
            r_total    <= frame_pixels(i_fm_dim);
            r_wr_cnt   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop)     r_wr_cnt   <= r_wr_cnt + 32'd1;
            if (w_ovf_set) r_overflow <= 1'b1;
        end
    end

`ifdef CONV2D_WR_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             r_stall_cycles <= '0;
        else if (w_start_frame)                 r_stall_cycles <= '0;
        else if (w_valid && !bus.mem_wreq_ready) r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_conv2d_result_writer.sv
// Directed bench for conv2d_result_writer: logs every accepted write, checks against hand values.
module tb_conv2d_result_writer;
    import conv2d_result_writer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start;
    logic        idle;
    logic        done;
    logic [31:0] base;
    logic [31:0] dim;
    logic        ovf;
`ifdef CONV2D_WR_PERF_EN
    logic [31:0] stall;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cyc  = 0;
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv2d_result_writer_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

    conv2d_result_writer #(.DWIDTH(32), .AWIDTH(32), .FIFO_LOGD(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .o_idle         (idle),
        .o_done         (done),
        .i_ofm_base     (base),
        .i_fm_dim       (dim),
        .o_overflow     (ovf),
`ifdef CONV2D_WR_PERF_EN
        .o_stall_cycles (stall),
`endif
        .bus            (bus)
    );

    always @(negedge clk) begin
        if (bus.mem_wreq_valid && bus.mem_wreq_ready) begin
            q_addr.push_back(bus.mem_wreq_addr);
            q_data.push_back(bus.mem_wreq_data);
            acc_cyc = cyc;
            $display("WR  cyc=%0d addr=0x%08h data=0x%08h", cyc, bus.mem_wreq_addr, bus.mem_wreq_data);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            $display("DONE cyc=%0d", cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] d);
        base  = b;
        dim   = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] v);
        bus.wdata       = v;
        bus.wdata_valid = 1'b1;
        tick();
        bus.wdata_valid = 1'b0;
    endtask

    task automatic clr();
        q_addr.delete();
        q_data.delete();
        done_cnt = 0;
    endtask

    initial begin
        start = 1'b0; base = '0; dim = '0;
        bus.wdata = '0; bus.wdata_valid = 1'b0; bus.mem_wreq_ready = 1'b0;
        repeat (2) tick();
        chk("rst_idle", idle, 1);
        chk("rst_valid", bus.mem_wreq_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        // 2x2 frame, one result every 10 cycles, memory always ready
        clr();
        bus.mem_wreq_ready = 1'b1;
        do_start(32'h100, 2);
        chk("t1_busy", idle, 0);
        for (int k = 1; k <= 4; k++) begin
            push(k);
            if (k == 1) chk("t1_latency", bus.mem_wreq_valid, 1);
            repeat (9) tick();
        end
        chk("t1_nwr", q_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_addr%0d", i), q_addr[i], 32'h100 + i);
            chk($sformatf("t1_data%0d", i), q_data[i], i + 1);
        end
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_lat", done_cyc - acc_cyc, 1);
        chk("t1_ovf", ovf, 0);
        chk("t1_idle", idle, 1);

        // 3x3 frame, memory stalled while 6 results arrive back to back
        clr();
        bus.mem_wreq_ready = 1'b0;
        do_start(32'h300, 3);
        for (int i = 0; i < 6; i++) push(32'h21 + i);
        repeat (14) tick();
        chk("t2_ovf", ovf, 1);
        chk("t2_hold_valid", bus.mem_wreq_valid, 1);
        chk("t2_hold_addr", bus.mem_wreq_addr, 32'h300);
        chk("t2_hold_data", bus.mem_wreq_data, 32'h21);
        chk("t2_nwr_stall", q_addr.size(), 0);
        bus.mem_wreq_ready = 1'b1;
        repeat (8) tick();
        chk("t2_nwr", q_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_addr%0d", i), q_addr[i], 32'h300 + i);
            chk($sformatf("t2_data%0d", i), q_data[i], 32'h21 + i);
        end
        chk("t2_no_done", done_cnt, 0);
        chk("t2_busy", idle, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // full FIFO with push and pop in the same cycle, then finish the frame
        clr();
        bus.mem_wreq_ready = 1'b0;
        do_start(32'h400, 3);
        for (int i = 0; i < 4; i++) push(32'h31 + i);
        bus.wdata = 32'h35;
        bus.wdata_valid = 1'b1;
        bus.mem_wreq_ready = 1'b1;
        tick();
        bus.wdata_valid = 1'b0;
        chk("t3_no_ovf", ovf, 0);
        repeat (6) tick();
        for (int i = 0; i < 4; i++) begin
            push(32'h36 + i);
            repeat (2) tick();
        end
        repeat (3) tick();
        chk("t3_nwr", q_addr.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t3_addr%0d", i), q_addr[i], 32'h400 + i);
            chk($sformatf("t3_data%0d", i), q_data[i], 32'h31 + i);
        end
        chk("t3_ovf_end", ovf, 0);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_idle", idle, 1);

        // results strobed while idle are ignored
        push(32'hEE);
        tick();
        chk("idle_ign_valid", bus.mem_wreq_valid, 0);
        chk("idle_ign_ovf", ovf, 0);
        chk("idle_ign_nwr", q_addr.size(), 9);

        // empty frame goes straight through DONE
        clr();
        do_start(32'h800, 0);
        chk("t4_done", done, 1);
        chk("t4_not_idle", idle, 0);
        tick();
        chk("t4_done_clr", done, 0);
        chk("t4_idle", idle, 1);
        repeat (3) tick();
        chk("t4_nwr", q_addr.size(), 0);
        chk("t4_done_cnt", done_cnt, 1);

        // asynchronous reset in the middle of a frame
        clr();
        bus.mem_wreq_ready = 1'b1;
        do_start(32'h500, 3);
        push(32'h51);
        push(32'h52);
        repeat (3) tick();
        chk("t5_nwr_pre", q_addr.size(), 2);
        bus.mem_wreq_ready = 1'b0;
        push(32'h53);
        chk("t5_valid_pre", bus.mem_wreq_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_idle", idle, 1);
        chk("t5_async_valid", bus.mem_wreq_valid, 0);
        #2;
        rst_n = 1'b1;
        tick();
        clr();
        bus.mem_wreq_ready = 1'b1;
        do_start(32'h200, 1);
        push(32'h77);
        repeat (3) tick();
        chk("t5_nwr", q_addr.size(), 1);
        chk("t5_addr", q_addr[0], 32'h200);
        chk("t5_data", q_data[0], 32'h77);
        chk("t5_done_cnt", done_cnt, 1);

        // address wraps modulo 2^32
        clr();
        do_start(32'hFFFF_FFFE, 2);
        for (int i = 0; i < 4; i++) push(32'hA1 + i);
        repeat (3) tick();
        chk("wrap_nwr", q_addr.size(), 4);
        chk("wrap_a0", q_addr[0], 32'hFFFF_FFFE);
        chk("wrap_a1", q_addr[1], 32'hFFFF_FFFF);
        chk("wrap_a2", q_addr[2], 32'h0000_0000);
        chk("wrap_a3", q_addr[3], 32'h0000_0001);
        chk("wrap_done", done_cnt, 1);

`ifdef CONV2D_WR_PERF_EN
        clr();
        bus.mem_wreq_ready = 1'b0;
        do_start(32'h600, 1);
        push(32'h61);
        repeat (7) tick();
        bus.mem_wreq_ready = 1'b1;
        tick();
        repeat (3) tick();
        chk("t6_stall", stall, 7);
        chk("t6_idle", idle, 1);
        chk("t6_nwr", q_addr.size(), 1);
        do_start(32'h700, 1);
        chk("t6_stall_clr", stall, 0);
        push(32'h71);
        repeat (3) tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
